// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: bus widths, ROM enables,
// stall-vector bit positions and the IF/ID bundle.
package if_fetch_stage_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t ZERO_WORD    = '0;
  localparam logic  CHIP_ENABLE  = 1'b1;
  localparam logic  CHIP_DISABLE = 1'b0;

  localparam int STALL_W    = 3;
  localparam int STALL_PC   = 0;
  localparam int STALL_IFID = 1;
  localparam int STALL_ID   = 2;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
    logic       valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    pc:    '0,
    inst:  ZERO_WORD,
    valid: 1'b0
  };

  function automatic inst_addr_t word_align(inst_addr_t a);
    return a & ~inst_addr_t'(3);
  endfunction

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter, ROM enable and the branch target held
// back while the PC is stalled.
module pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold_i,
  input  logic       flush_i,
  input  inst_addr_t flush_pc_i,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_i,
  output inst_addr_t pc_o,
  output logic       ce_o,
  output logic       redirect_o
);

  inst_addr_t pc_q;
  inst_addr_t pc_d;
  inst_addr_t pend_q;
  inst_addr_t pend_d;
  logic       pend_v_q;
  logic       pend_v_d;
  logic       ce_q;
  logic       redirect;

  always_comb begin
    pc_d     = pc_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    redirect = 1'b0;
    if (ce_q == CHIP_ENABLE) begin
      if (flush_i) begin
        pc_d     = flush_pc_i;
        pend_v_d = 1'b0;
      end else if (hold_i) begin
        // a redirect seen during a stall is replayed once it clears
        if (branch_flag_i) begin
          pend_v_d = 1'b1;
          pend_d   = word_align(branch_target_i);
        end
      end else if (pend_v_q) begin
        pc_d     = pend_q;
        pend_v_d = 1'b0;
        redirect = 1'b1;
      end else if (branch_flag_i) begin
        pc_d     = word_align(branch_target_i);
        redirect = 1'b1;
      end else begin
        pc_d = pc_q + inst_addr_t'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ce_q     <= CHIP_DISABLE;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ce_q     <= CHIP_ENABLE;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = ce_q;
  assign redirect_o = redirect;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: drives the ROM from pc_reg and captures
// the returned word into the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC   = 32'h0000_0000,
  parameter bit         DELAY_SLOT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  inst_addr_t         flush_pc_i,
  input  logic               branch_flag_i,
  input  inst_addr_t         branch_target_i,
  output inst_addr_t         rom_addr_o,
  output logic               rom_ce_o,
  input  inst_t              rom_data_i,
  output inst_addr_t         id_pc_o,
  output inst_t              id_inst_o,
  output logic               id_valid_o
);

  localparam bit SQUASH_EN = !DELAY_SLOT;

  inst_addr_t pc;
  logic       ce;
  logic       redirect;
  logic       squash;
  logic       hold_ifid;
  logic       hold_id;
  if_id_t     id_q;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .hold_i          (stall_i[STALL_PC]),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc),
    .ce_o            (ce),
    .redirect_o      (redirect)
  );

  assign hold_ifid = stall_i[STALL_IFID];
  assign hold_id   = stall_i[STALL_ID];
  assign squash    = SQUASH_EN && redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q <= IF_ID_BUBBLE;
    end else if (flush_i) begin
      id_q <= IF_ID_BUBBLE;
    end else if (hold_ifid && !hold_id) begin
      // ID drains while IF is held: feed it a bubble
      id_q <= IF_ID_BUBBLE;
    end else if (hold_ifid) begin
      id_q <= id_q;
    end else if (squash) begin
      id_q <= IF_ID_BUBBLE;
    end else begin
      id_q <= '{pc: pc, inst: rom_data_i, valid: ce};
    end
  end

  assign rom_addr_o = pc;
  assign rom_ce_o   = ce;
  assign id_pc_o    = id_q.pc;
  assign id_inst_o  = id_q.inst;
  assign id_valid_o = id_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: one instance per delay-slot mode
// against a rule-level reference model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        bf;
  logic [31:0] bt;

  logic [31:0] addr1, data1, ipc1, iinst1;
  logic        ce1, iv1;
  logic [31:0] addr0, data0, ipc0, iinst0;
  logic        ce0, iv0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(logic [31:0] a);
    case (a)
      32'h0:   return 32'h3401_1100;
      32'h4:   return 32'h3402_0020;
      32'h8:   return 32'h3403_FF00;
      32'hC:   return 32'h3404_FFFF;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign data1 = ce1 ? rom_word(addr1) : 32'h0;
  assign data0 = ce0 ? rom_word(addr0) : 32'h0;

  if_fetch_stage #(
    .RESET_PC   (32'h0),
    .DELAY_SLOT (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .flush_i         (flush),
    .flush_pc_i      (flush_pc),
    .branch_flag_i   (bf),
    .branch_target_i (bt),
    .rom_addr_o      (addr1),
    .rom_ce_o        (ce1),
    .rom_data_i      (data1),
    .id_pc_o         (ipc1),
    .id_inst_o       (iinst1),
    .id_valid_o      (iv1)
  );

  if_fetch_stage #(
    .RESET_PC   (32'h0),
    .DELAY_SLOT (1'b0)
  ) dut_nds (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .flush_i         (flush),
    .flush_pc_i      (flush_pc),
    .branch_flag_i   (bf),
    .branch_target_i (bt),
    .rom_addr_o      (addr0),
    .rom_ce_o        (ce0),
    .rom_data_i      (data0),
    .id_pc_o         (ipc0),
    .id_inst_o       (iinst0),
    .id_valid_o      (iv0)
  );

  typedef struct {
    logic [31:0] pc;
    bit          ce;
    bit          pv;
    logic [31:0] pt;
    logic [31:0] ipc;
    logic [31:0] iinst;
    bit          iv;
  } mst_t;

  mst_t m1, m0;

  function automatic mst_t model_reset();
    mst_t s;
    s.pc = 32'h0; s.ce = 0; s.pv = 0; s.pt = 32'h0;
    s.ipc = 32'h0; s.iinst = 32'h0; s.iv = 0;
    return s;
  endfunction

  // next state after one edge, from the stage's priority rules
  function automatic mst_t step(mst_t s, bit ds);
    mst_t n = s;
    bit taken = 0;
    bit bubble;
    logic [31:0] inst = s.ce ? rom_word(s.pc) : 32'h0;
    n.ce = 1;
    if (s.ce) begin
      if (flush) begin
        n.pc = flush_pc; n.pv = 0;
      end else if (stall[0]) begin
        if (bf) begin n.pv = 1; n.pt = {bt[31:2], 2'b00}; end
      end else if (s.pv) begin
        n.pc = s.pt; n.pv = 0; taken = 1;
      end else if (bf) begin
        n.pc = {bt[31:2], 2'b00}; taken = 1;
      end else begin
        n.pc = s.pc + 32'd4;
      end
    end
    bubble = flush || (stall[1] && !stall[2]) || (!stall[1] && !ds && taken);
    if (bubble) begin
      n.ipc = 0; n.iinst = 0; n.iv = 0;
    end else if (!stall[1]) begin
      n.ipc = s.pc; n.iinst = inst; n.iv = s.ce;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("ds1_addr", addr1, m1.pc);
    check("ds1_ce", 32'(ce1), 32'(m1.ce));
    check("ds1_id_pc", ipc1, m1.ipc);
    check("ds1_id_inst", iinst1, m1.iinst);
    check("ds1_id_valid", 32'(iv1), 32'(m1.iv));
    check("ds0_addr", addr0, m0.pc);
    check("ds0_ce", 32'(ce0), 32'(m0.ce));
    check("ds0_id_pc", ipc0, m0.ipc);
    check("ds0_id_inst", iinst0, m0.iinst);
    check("ds0_id_valid", 32'(iv0), 32'(m0.iv));
  endtask

  task automatic tick();
    mst_t n1, n0;
    n1 = step(m1, 1'b1);
    n0 = step(m0, 1'b0);
    @(posedge clk);
    #1;
    m1 = n1;
    m0 = n0;
    check_all();
  endtask

  task automatic idle();
    stall = 3'b000; flush = 0; flush_pc = 0; bf = 0; bt = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    m1 = model_reset();
    m0 = model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #3;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    apply_reset();

    tick();
    check("ce_rise", 32'(ce1), 32'h1);
    check("first_addr", addr1, 32'h0);
    tick();
    check("addr_4", addr1, 32'h4);
    check("inst_0", iinst1, 32'h3401_1100);
    tick();
    check("addr_8", addr1, 32'h8);
    check("inst_4", iinst1, 32'h3402_0020);

    bf = 1; bt = 32'h43;
    tick();
    bf = 0; bt = 0;
    check("br_pc", addr1, 32'h40);
    check("ds1_slot", iinst1, 32'h3403_FF00);
    check("ds1_slot_v", 32'(iv1), 32'h1);
    check("ds0_slot", iinst0, 32'h0);
    check("ds0_slot_v", 32'(iv0), 32'h0);

    flush = 1; flush_pc = 32'h4;
    tick();
    flush = 0;
    stall = 3'b011; bf = 1; bt = 32'h20;
    tick();
    bf = 0;
    check("stall_pc", addr1, 32'h4);
    check("stall_bub", iinst1, 32'h0);
    tick();
    stall = 3'b000;
    tick();
    check("pend_pc", addr1, 32'h20);

    stall = 3'b001; bf = 1; bt = 32'h300;
    tick();
    bf = 0; flush = 1; flush_pc = 32'h180;
    tick();
    check("flush_pc", addr1, 32'h180);
    check("flush_bub", 32'(iv1), 32'h0);
    flush = 0; stall = 3'b000;
    tick();
    check("pend_drop", addr1, 32'h184);

    stall = 3'b111;
    repeat (3) tick();
    stall = 3'b000;
    repeat (2) tick();

    flush = 1; flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 0;
    tick();
    check("wrap", addr1, 32'h0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset();
      end
      flush    = ($urandom_range(0, 15) == 0);
      flush_pc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFC);
      bf       = ($urandom_range(0, 3) == 0);
      bt       = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 255);
      case ($urandom_range(0, 7))
        0, 1, 2: stall = 3'b000;
        3:       stall = 3'b001;
        4:       stall = 3'b011;
        5:       stall = 3'b111;
        default: stall = 3'($urandom);
      endcase
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
